// File: rtl/image_feed.sv
// Kernel-window pixel streamer: buffer reads -> 4-entry FIFO -> image stream.
// Optional IMAGE_FEED_STALL_CNT_EN adds a saturating stall_cnt output.
`timescale 1ns/1ps
module image_feed #(
    parameter int CFG_DWIDTH    = 32,
    parameter int CFG_AWIDTH    = 5,
    parameter int CFG_FEED_ADDR = 6,
    parameter int GROUP_NB      = 4,
    parameter int IMG_WIDTH     = 16,
    parameter int MEM_AWIDTH    = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CFG_DWIDTH-1:0]         cfg_data,
    input  logic [CFG_AWIDTH-1:0]         cfg_addr,
    input  logic                          cfg_valid,
    input  logic                          start,
    input  logic [MEM_AWIDTH-1:0]         start_addr,
    output logic                          busy,
    output logic                          done,
    output logic                          rd_en,
    output logic [MEM_AWIDTH-1:0]         rd_addr,
    input  logic [GROUP_NB*IMG_WIDTH-1:0] rd_data,
    output logic [GROUP_NB*IMG_WIDTH-1:0] image_bus,
    output logic                          image_val,
    output logic                          image_last,
    input  logic                          image_rdy
`ifdef IMAGE_FEED_STALL_CNT_EN
    ,
    output logic [31:0]                   stall_cnt
`endif
);

    localparam int DW = GROUP_NB * IMG_WIDTH;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t                state_q, state_d;
    logic [MEM_AWIDTH-1:0] stride_s, stride_q;
    logic [7:0]            kw_s, kh_s, kw_q, kh_q;
    logic [MEM_AWIDTH-1:0] row_base_q, row_base_d;
    logic [MEM_AWIDTH-1:0] col_addr_q, col_addr_d;
    logic [7:0]            col_q, col_d, row_q, row_d;
    logic                  v1_q, v2_q, l1_q, l2_q;
    logic [1:0]            wp_q, rp_q;
    logic [2:0]            count_q;
    logic [2:0]            credits;
    logic [DW-1:0]         dat_mem [4];
    logic                  lst_mem [4];
    logic                  start_ok, last_rd, xfer, head_last;

    always_ff @(posedge clk) begin
        if (cfg_valid && cfg_addr == CFG_AWIDTH'(CFG_FEED_ADDR)) begin
            stride_s <= cfg_data[16 +: MEM_AWIDTH];
            kh_s     <= cfg_data[15:8];
            kw_s     <= cfg_data[7:0];
        end
    end

    assign start_ok = (state_q == IDLE) && start;

    // Working geometry is frozen per window; zero sizes mean one.
    always_ff @(posedge clk) begin
        if (start_ok) begin
            stride_q <= stride_s;
            kw_q     <= (kw_s == 8'd0) ? 8'd1 : kw_s;
            kh_q     <= (kh_s == 8'd0) ? 8'd1 : kh_s;
        end
    end

    assign credits   = count_q + {2'b00, v1_q} + {2'b00, v2_q};
    assign rd_en     = (state_q == FETCH) && (credits < 3'd4);
    assign rd_addr   = col_addr_q;
    assign last_rd   = (col_q == kw_q - 8'd1) && (row_q == kh_q - 8'd1);
    assign image_val = (count_q != 3'd0);
    assign image_bus = dat_mem[rp_q];
    assign head_last = lst_mem[rp_q];
    assign image_last = image_val && head_last;
    assign xfer      = image_val && image_rdy;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);

    always_comb begin
        state_d    = state_q;
        row_base_d = row_base_q;
        col_addr_d = col_addr_q;
        col_d      = col_q;
        row_d      = row_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = FETCH;
                    row_base_d = start_addr;
                    col_addr_d = start_addr;
                    col_d      = 8'd0;
                    row_d      = 8'd0;
                end
            end
            FETCH: begin
                if (rd_en) begin
                    if (col_q == kw_q - 8'd1) begin
                        col_d      = 8'd0;
                        row_d      = row_q + 8'd1;
                        row_base_d = row_base_q + stride_q;
                        col_addr_d = row_base_q + stride_q;
                    end else begin
                        col_d      = col_q + 8'd1;
                        col_addr_d = col_addr_q + 1'b1;
                    end
                    if (last_rd) state_d = DRAIN;
                end
            end
            DRAIN: begin
                // The tagged beat is the final datum, so its transfer drains all.
                if (!v1_q && !v2_q && count_q == 3'd1 && xfer && head_last)
                    state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            row_base_q <= '0;
            col_addr_q <= '0;
            col_q      <= '0;
            row_q      <= '0;
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            l1_q       <= 1'b0;
            l2_q       <= 1'b0;
            wp_q       <= '0;
            rp_q       <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            row_base_q <= row_base_d;
            col_addr_q <= col_addr_d;
            col_q      <= col_d;
            row_q      <= row_d;
            v1_q       <= rd_en;
            l1_q       <= rd_en && last_rd;
            v2_q       <= v1_q;
            l2_q       <= l1_q;
            wp_q       <= wp_q + {1'b0, v2_q};
            rp_q       <= rp_q + {1'b0, xfer};
            count_q    <= count_q + {2'b00, v2_q} - {2'b00, xfer};
        end
    end

    always_ff @(posedge clk) begin
        if (v2_q) begin
            dat_mem[wp_q] <= rd_data;
            lst_mem[wp_q] <= l2_q;
        end
    end

`ifdef IMAGE_FEED_STALL_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk) begin
        if (rst)
            stall_q <= '0;
        else if (start_ok)
            stall_q <= '0;
        else if (image_val && !image_rdy && !(&stall_q))
            stall_q <= stall_q + 32'd1;
    end

    assign stall_cnt = stall_q;
`endif

endmodule
